serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor. It is the sequential successor of the single-bit combinational full adder. It processes a WIDTH-bit operand pair DIGIT bits per clock through a DIGIT-bit ripple slice, with the carry held in a register between slices. It sits beside the ALU datapath where area matters more than latency, and adds a subtract mode and a signed-overflow flag.

---
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder.sv | 104 ++++++++++
 tb/tb_serial_adder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: request side drives operands and start,
// the adder returns busy/done and the registered result flags.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             c_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, sub, c_in, a, b,
        input  busy, done, s, c_out, overflow
    );

    modport slave (
        input  start, sub, c_in, a, b,
        output busy, done, s, c_out, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock
// through a ripple slice, carry held between slices; signed-overflow flag on completion.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1   // WIDTH must be an exact multiple of DIGIT
) (
    input logic         clk,
    input logic         rst_n,
    serial_adder_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             last_step;
    logic             accept;
    logic [DIGIT-1:0] slice_sum;
    logic [DIGIT:0]   slice_c;
    logic [WIDTH-1:0] s_q;
    logic             c_out_q, overflow_q;

    assign accept    = bus.start && (state == IDLE || state == DONE);
    assign last_step = (cnt == CNT_W'(STEPS - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode straight off the state flops, so busy/done never overlap.
    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    // Ripple slice; slice_c[DIGIT-1] is the carry into the slice's top bit.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        slice_c    = '0;
        slice_sum  = '0;
        slice_c[0] = carry;
        for (int i = 0; i < DIGIT; i++) begin
            slice_sum[i]  = a_sr[i] ^ b_sr[i] ^ slice_c[i];
            slice_c[i+1]  = (a_sr[i] & b_sr[i]) | (slice_c[i] & (a_sr[i] ^ b_sr[i]));
        end
        sum_next = (sum_sr >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
    end

    // Subtract is a + ~b + ~borrow_in, so B is inverted and the carry seed flipped at load.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: shift registers are plain flops here, not RAM, so they are reset like any other state.
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            sum_sr     <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            s_q        <= '0;
            c_out_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b ^ {WIDTH{bus.sub}};
            carry <= bus.c_in ^ bus.sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> DIGIT;
            b_sr   <= b_sr >> DIGIT;
            sum_sr <= sum_next;
            carry  <= slice_c[DIGIT];
            cnt    <= cnt + 1'b1;
            if (last_step) begin
                s_q        <= sum_next;
                c_out_q    <= slice_c[DIGIT];
                overflow_q <= slice_c[DIGIT] ^ slice_c[DIGIT-1];
            end
        end
    end

    assign bus.s        = s_q;
    assign bus.c_out    = c_out_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: 8-bit/1-digit and 16-bit/4-digit instances, table vectors,
// random ops against an arithmetic model, and handshake corner sequences.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  bus8 ();
    serial_adder_if #(.WIDTH(16)) bus16 ();

    serial_adder #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    typedef struct {
        logic [15:0] s;
        logic        c_out;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [7:0] s;
        logic       c_out;
        logic       ovf;
    } vec_t;

    exp_t q8[$];
    exp_t q16[$];
    int   total = 0;
    int   bad = 0;
    int   done8_cnt = 0;
    int   done16_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Sign-rule overflow on the effective addition a + b' + c'.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input logic cin);
        exp_t        r;
        logic [15:0] mask, bb;
        logic [16:0] full;
        logic        cc;
        mask    = (w == 16) ? 16'hFFFF : 16'h00FF;
        bb      = (sub ? ~b : b) & mask;
        cc      = sub ? ~cin : cin;
        full    = {1'b0, a & mask} + {1'b0, bb} + 17'(cc);
        r.s     = full[15:0] & mask;
        r.c_out = full[w];
        r.ovf   = (a[w-1] == bb[w-1]) && (r.s[w-1] != a[w-1]);
        return r;
    endfunction

    // Scoreboard monitors: pop on each done pulse.
    always @(negedge clk) begin
        if (bus8.done) begin
            exp_t e;
            done8_cnt++;
            check("done8_not_busy", bus8.busy, 0);
            check("sb8_nonempty", q8.size() > 0, 1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check("res8_s", bus8.s, e.s);
                check("res8_cout", bus8.c_out, e.c_out);
                check("res8_ovf", bus8.overflow, e.ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (bus16.done) begin
            exp_t e;
            done16_cnt++;
            check("done16_not_busy", bus16.busy, 0);
            check("sb16_nonempty", q16.size() > 0, 1);
            if (q16.size() > 0) begin
                e = q16.pop_front();
                check("res16_s", bus16.s, e.s);
                check("res16_cout", bus16.c_out, e.c_out);
                check("res16_ovf", bus16.overflow, e.ovf);
            end
        end
    end

    // Drives start for one edge; returns at the negedge right after the sampling edge.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                          input logic cin, input exp_t e, input bit push);
        @(negedge clk);
        bus8.a = a; bus8.b = b; bus8.sub = sub; bus8.c_in = cin; bus8.start = 1'b1;
        if (push) q8.push_back(e);
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        bus8.sub = 1'($urandom); bus8.c_in = 1'($urandom);
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                           input logic cin);
        @(negedge clk);
        bus16.a = a; bus16.b = b; bus16.sub = sub; bus16.c_in = cin; bus16.start = 1'b1;
        q16.push_back(model(16, a, b, sub, cin));
        @(negedge clk);
        bus16.start = 1'b0;
        bus16.a = 16'($urandom); bus16.b = 16'($urandom);
    endtask

    task automatic wait8(input string name);
        for (int i = 0; i < 100 && (q8.size() != 0 || bus8.busy); i++) @(negedge clk);
        check(name, q8.size(), 0);
    endtask

    task automatic wait16(input string name);
        for (int i = 0; i < 100 && (q16.size() != 0 || bus16.busy); i++) @(negedge clk);
        check(name, q16.size(), 0);
    endtask

    initial begin
        vec_t vecs[9];
        int   busy_cycles;
        int   d0;
        exp_t e;
        logic [15:0] ra, rb;
        logic rs, rc;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[8] = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};

        bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.sub = 1'b0;  bus8.c_in = 1'b0;
        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.sub = 1'b0; bus16.c_in = 1'b0;

        #1;
        check("reset8_outs", {bus8.busy, bus8.done, bus8.s, bus8.c_out, bus8.overflow}, 0);
        check("reset16_outs", {bus16.busy, bus16.done, bus16.s, bus16.c_out, bus16.overflow}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Latency/handshake timing on the first spec vector.
        e.s = 16'h008D; e.c_out = 1'b0; e.ovf = 1'b1;
        start8(8'h5A, 8'h33, 1'b0, 1'b0, e, 1'b1);
        busy_cycles = 0;
        d0 = done8_cnt;
        for (int i = 0; i < 8; i++) begin
            if (bus8.busy && !bus8.done) busy_cycles++;
            @(negedge clk);
        end
        check("busy_len8", busy_cycles, 8);
        check("no_early_done8", done8_cnt - d0, 0);
        check("done_at_t8", {bus8.busy, bus8.done}, 2'b01);
        @(negedge clk);
        check("done_one_cycle8", bus8.done, 0);
        wait8("drain_timing8");

        // Table vectors.
        for (int i = 0; i < 9; i++) begin
            e.s = {8'h00, vecs[i].s}; e.c_out = vecs[i].c_out; e.ovf = vecs[i].ovf;
            start8(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, e, 1'b1);
            wait8("drain_vec8");
        end

        // Random operations against the model.
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255));
            rs = 1'($urandom); rc = 1'($urandom);
            start8(ra[7:0], rb[7:0], rs, rc, model(8, ra, rb, rs, rc), 1'b1);
            wait8("drain_rand8");
        end

        // start re-asserted at edge 3 of a run must be ignored.
        d0 = done8_cnt;
        start8(8'h12, 8'h34, 1'b0, 1'b0, model(8, 16'h12, 16'h34, 1'b0, 1'b0), 1'b1);
        @(negedge clk);
        @(negedge clk);
        bus8.a = 8'hAA; bus8.b = 8'h77; bus8.sub = 1'b1; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        wait8("drain_ignore8");
        repeat (12) @(negedge clk);
        check("ignored_start_one_done", done8_cnt - d0, 1);

        // Asynchronous abort after edge 4 of a run.
        d0 = done8_cnt;
        start8(8'h21, 8'h43, 1'b0, 1'b0, e, 1'b0);
        repeat (4) @(negedge clk);
        check("abort_pre_busy", bus8.busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_outs", {bus8.busy, bus8.done, bus8.s, bus8.c_out, bus8.overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", done8_cnt - d0, 0);
        start8(8'h21, 8'h43, 1'b0, 1'b0, model(8, 16'h21, 16'h43, 1'b0, 1'b0), 1'b1);
        wait8("drain_after_abort8");

        // 16-bit, 4-bit digits: latency 5.
        start16(16'h1234, 16'hEDCC, 1'b0, 1'b0);
        busy_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus16.busy && !bus16.done) busy_cycles++;
            @(negedge clk);
        end
        check("busy_len16", busy_cycles, 4);
        check("done_at_t4", {bus16.busy, bus16.done}, 2'b01);
        wait16("drain_lat16");

        // start held high through the done cycle: back-to-back accept.
        d0 = done16_cnt;
        @(negedge clk);
        bus16.a = 16'h7FFF; bus16.b = 16'h0001; bus16.sub = 1'b0; bus16.c_in = 1'b0;
        bus16.start = 1'b1;
        q16.push_back(model(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0));
        for (int i = 0; i < 20 && !bus16.done; i++) @(negedge clk);
        check("b2b_first_done", bus16.done, 1);
        bus16.a = 16'h8000; bus16.b = 16'h0001; bus16.sub = 1'b1;
        q16.push_back(model(16, 16'h8000, 16'h0001, 1'b1, 1'b0));
        @(negedge clk);
        check("b2b_accept", {bus16.busy, bus16.done}, 2'b10);
        bus16.start = 1'b0;
        wait16("drain_b2b16");
        check("b2b_two_dones", done16_cnt - d0, 2);

        for (int i = 0; i < 8; i++) begin
            start16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            wait16("drain_rand16");
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
